prio_encoder_arb: RTL and testbench

- Parametrised, registered successor to the team's combinational 8x3 priority encoder.
- Captures N request lines into a sticky pending register.
- Grants one index per handshake, either fixed-priority (bit 0 highest, the existing encoder's ordering) or round-robin.
- Sits between request sources (interrupt/event lines) and a single consumer with valid/ready flow control.

---
 rtl/prio_encoder_pkg.sv | 16 +
 rtl/prio_pick.sv | 47 ++++
 rtl/prio_encoder_arb.sv | 110 +++++++++++
 tb/tb_prio_encoder_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder / arbiter.
package prio_encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Successor of index s in a ring of n entries; n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned s, input int unsigned n);
    if (s >= n - 32'd1) begin
      return 32'd0;
    end else begin
      return s + 32'd1;
    end
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first-set over an N-bit vector, starting the scan at a
// given index and wrapping around (double-width mask technique).
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] masked_s;

  // Drop bits below start in the lower copy; the upper copy supplies the wrap.
  always_comb begin
    dbl_s    = {vec, vec};
    masked_s = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (i >= int'(start)) begin
        masked_s[i] = dbl_s[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end
  end

  // Lowest set bit of the masked vector, folded back into 0..N-1.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked_s[i]) begin
        found = 1'b1;
        if (i >= N) begin
          idx = W'(i - N);
        end else begin
          idx = W'(i);
        end
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_arb.sv
// Sticky pending register feeding a one-entry valid/ready output stage that
// grants one request index per handshake, fixed-priority or round-robin.
module prio_encoder_arb
  import prio_encoder_pkg::*;
#(
  parameter  int N  = 8,
  localparam int W  = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rr_en,
  input  logic          in_valid,
  input  logic [N-1:0]  in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] pend_cnt
);

  logic [N-1:0]  pending_q, pending_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic          load_s;
  logic          sel_s;
  logic [W-1:0]  start_s;
  logic          found_s;
  logic [W-1:0]  pick_idx_s;
  logic [N-1:0]  sel_clr_s;

  // Selection always looks at the registered pending vector, never at in.
  prio_pick #(.N(N)) u_pick (
    .vec   (pending_q),
    .start (start_s),
    .found (found_s),
    .idx   (pick_idx_s)
  );

  // Next-state logic for pending, pointer and output stage.
  always_comb begin
    load_s = !out_valid_q || out_ready;
    if (rr_en == MODE_RR) begin
      start_s = ptr_q;
    end else begin
      start_s = '0;
    end
    sel_s = load_s && found_s;

    sel_clr_s = '0;
    if (sel_s) begin
      sel_clr_s[pick_idx_s] = 1'b1;
    end else begin
      sel_clr_s = '0;
    end

    // Set is applied after clear so a re-request of the granted index survives.
    if (in_valid) begin
      pending_d = (pending_q & ~sel_clr_s) | in;
    end else begin
      pending_d = pending_q & ~sel_clr_s;
    end

    pend_cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(pending_d[i]);
    end

    out_valid_d = out_valid_q;
    out_d       = out_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      out_valid_d = found_s;
      if (found_s) begin
        out_d = pick_idx_s;
        ptr_d = W'(wrap_inc(32'(pick_idx_s), 32'(N)));
      end else begin
        out_d = out_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      pend_cnt_q  <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_cnt_q  <= pend_cnt_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign pending   = pending_q;
  assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Self-checking bench: an N=8 and an N=5 arbiter checked every cycle against a
// behavioural ring-scan model, plus directed scenarios with literal expectations.
module tb_prio_encoder_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rr_en = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in8 = 8'h00;
  logic [4:0] in5 = 5'h00;

  logic       ov8, ov5;
  logic [2:0] out8, out5;
  logic [7:0] pend8;
  logic [4:0] pend5;
  logic [3:0] cnt8;
  logic [2:0] cnt5;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model state: instance 0 is N=8, instance 1 is N=5.
  bit [7:0] m_pend [2];
  int       m_ptr  [2];
  bit       m_ov   [2];
  int       m_out  [2];

  always #5 clk = ~clk;

  prio_encoder_arb #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .rr_en(rr_en), .in_valid(in_valid), .in(in8),
    .out_valid(ov8), .out_ready(out_ready), .out(out8), .pending(pend8), .pend_cnt(cnt8)
  );

  prio_encoder_arb #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .rr_en(rr_en), .in_valid(in_valid), .in(in5),
    .out_valid(ov5), .out_ready(out_ready), .out(out5), .pending(pend5), .pend_cnt(cnt5)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int n, input bit [7:0] vec);
    int  start;
    int  sel;
    int  j;
    bit  [7:0] mask;
    mask = 8'((1 << n) - 1);
    if (rst) begin
      m_pend[k] = 8'h00;
      m_ptr[k]  = 0;
      m_ov[k]   = 1'b0;
      m_out[k]  = 0;
    end else begin
      if (!m_ov[k] || out_ready) begin
        start = rr_en ? m_ptr[k] : 0;
        sel = -1;
        for (int t = 0; t < n; t++) begin
          j = (start + t) % n;
          if (sel < 0 && m_pend[k][j]) sel = j;
        end
        if (sel >= 0) begin
          m_out[k] = sel;
          m_ov[k]  = 1'b1;
          m_ptr[k] = (sel + 1) % n;
          m_pend[k][sel] = 1'b0;
        end else begin
          m_ov[k] = 1'b0;
        end
      end
      if (in_valid) m_pend[k] = m_pend[k] | (vec & mask);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 8, in8);
    model_step(1, 5, {3'b000, in5});
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m8_pending", int'(pend8), int'(m_pend[0]));
      check("m8_cnt",     int'(cnt8),  $countones(m_pend[0]));
      check("m8_valid",   int'(ov8),   int'(m_ov[0]));
      check("m8_out",     int'(out8),  m_out[0]);
      check("m5_pending", int'(pend5), int'(m_pend[1]));
      check("m5_cnt",     int'(cnt5),  $countones(m_pend[1]));
      check("m5_valid",   int'(ov5),   int'(m_ov[1]));
      check("m5_out",     int'(out5),  m_out[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in8 = 8'h00; in5 = 5'h00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all requests asserted: everything stays cleared.
    rst = 1'b1; in_valid = 1'b1; in8 = 8'hFF; in5 = 5'h1F; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_en = 1'b1;
      check("rst_pending", int'(pend8), 0);
      check("rst_cnt",     int'(cnt8),  0);
      check("rst_valid",   int'(ov8),   0);
      check("rst_out",     int'(out8),  0);
    end

    // Fixed priority drains 2, 5, 7.
    rst = 1'b0; rr_en = 1'b0; in_valid = 1'b1; in8 = 8'b1010_0100; in5 = 5'h00;
    tick();
    in_valid = 1'b0;
    check("fix_cnt0", int'(cnt8), 3);
    check("fix_v0",   int'(ov8),  0);
    tick(); check("fix_out_a", int'(out8), 2); check("fix_cnt_a", int'(cnt8), 2);
    tick(); check("fix_out_b", int'(out8), 5); check("fix_cnt_b", int'(cnt8), 1);
    tick(); check("fix_out_c", int'(out8), 7); check("fix_cnt_c", int'(cnt8), 0);
    tick(); check("fix_v_end", int'(ov8), 0);

    // Starvation in fixed mode: index 0 wins every cycle.
    do_reset();
    rr_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in8 = 8'h81;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick(); check("starve_out", int'(out8), 0); check("starve_v", int'(ov8), 1);
    end

    // Round robin alternates 0, 7, 0, 7.
    do_reset();
    rr_en = 1'b1; in_valid = 1'b1; in8 = 8'h81;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick(); check("rr_out", int'(out8), (c % 2 == 0) ? 0 : 7);
    end

    // Backpressure: 3 held while 4 accumulates.
    do_reset();
    rr_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in8 = 8'h08;
    tick();
    in_valid = 1'b0;
    tick(); check("bp_out0", int'(out8), 3);
    in_valid = 1'b1; in8 = 8'h10;
    for (int c = 0; c < 5; c++) begin
      tick();
      in_valid = 1'b0;
      check("bp_hold_out", int'(out8), 3);
      check("bp_hold_v",   int'(ov8),  1);
    end
    check("bp_pending", int'(pend8), 8'h10);
    out_ready = 1'b1;
    tick(); check("bp_next", int'(out8), 4);

    // Non-power-of-two ring: 0, 4, 0, 4, never above 4.
    do_reset();
    rr_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in5 = 5'b10001;
    tick();
    for (int c = 0; c < 6; c++) begin
      tick(); check("n5_out", int'(out5), (c % 2 == 0) ? 0 : 4);
    end

    // Reset while a grant is held.
    do_reset();
    rr_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in8 = 8'h40;
    tick();
    in8 = 8'h0F;
    tick();
    in_valid = 1'b0;
    check("mid_out", int'(out8), 6); check("mid_pend", int'(pend8), 8'h0F);
    rst = 1'b1; in_valid = 1'b1; in8 = 8'hFF;
    tick();
    check("mid_rst_v", int'(ov8), 0); check("mid_rst_pend", int'(pend8), 0);
    rst = 1'b0; rr_en = 1'b1; out_ready = 1'b1; in8 = 8'h40;
    tick();
    in_valid = 1'b0;
    tick(); check("mid_regrant", int'(out8), 6);

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rr_en     = ($urandom_range(0, 31) == 0) ? ~rr_en : rr_en;
      in_valid  = ($urandom_range(0, 2) == 0);
      in8       = 8'($urandom);
      in5       = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
